// File: rtl/poly_matvec_scheduler.sv
// Drives a shared registered polynomial multiplier to compute t = A*s mod Q (K x K matrix).
// Define PMM_ADD_E_EN to latch an extra error vector e and produce t = A*s + e.
module poly_matvec_scheduler #(
    parameter int unsigned K  = 2,
    parameter int unsigned N  = 4,
    parameter int unsigned Q  = 17,
    parameter int unsigned CW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K*K*N*CW-1:0]   a_flat,
    input  logic [K*N*CW-1:0]     s_flat,
`ifdef PMM_ADD_E_EN
    input  logic [K*N*CW-1:0]     e_flat,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K*N*CW-1:0]     t_flat,
    output logic                  mul_en,
    output logic [N*CW-1:0]       mul_a,
    output logic [N*CW-1:0]       mul_b,
    input  logic [N*CW-1:0]       mul_res,
    output logic                  busy
);

    localparam int unsigned IW      = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(K - 1);
    localparam logic [CW-1:0] QV      = CW'(Q);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StAcc,
`ifdef PMM_ADD_E_EN
        StAddE,
`endif
        StDone
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   a_q   [K][K][N];
    logic [CW-1:0]   s_q   [K][N];
`ifdef PMM_ADD_E_EN
    logic [CW-1:0]   e_q   [K][N];
    logic            to_adde;
`endif
    logic [CW-1:0]   acc_q   [K][N];
    logic [CW-1:0]   acc_upd [K][N];
    logic [IW-1:0]   i_q, j_q, nxt_i, nxt_j;
    logic            row_last, to_done;
    logic [CW-1:0]   addend, row_sum;
    logic [N*CW-1:0] issue_a, issue_b;
    logic [K*N*CW-1:0] upd_flat;

    always_comb begin
        row_last = (j_q == LastIdx);
        nxt_i    = row_last ? i_q + IW'(1) : i_q;
        nxt_j    = row_last ? '0 : j_q + IW'(1);
`ifdef PMM_ADD_E_EN
        to_adde  = (state_q == StAcc) && row_last;
        to_done  = (state_q == StAddE) && (i_q == LastIdx);
`else
        to_done  = row_last && (i_q == LastIdx);
`endif
        acc_upd = acc_q;
        addend  = '0;
        row_sum = '0;
        // Current row gains either the normalized product or e[i]; both stay below 2Q-1.
        for (int c = 0; c < N; c++) begin
            addend = mul_res[c*CW +: CW];
            if (addend[CW-1]) addend = addend + QV;
`ifdef PMM_ADD_E_EN
            if (state_q == StAddE) addend = e_q[i_q][c];
`endif
            row_sum = acc_q[i_q][c] + addend;
            if (row_sum >= QV) row_sum = row_sum - QV;
            acc_upd[i_q][c] = row_sum;
        end
        for (int c = 0; c < N; c++) begin
            issue_a[c*CW +: CW] = a_q[nxt_i][nxt_j][c];
            issue_b[c*CW +: CW] = s_q[nxt_j][c];
        end
        for (int i = 0; i < K; i++) begin
            for (int c = 0; c < N; c++) begin
                upd_flat[(i*N+c)*CW +: CW] = acc_upd[i][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mul_en    <= 1'b0;
            busy      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            t_flat    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            for (int i = 0; i < K; i++) begin
                for (int c = 0; c < N; c++) begin
                    for (int j = 0; j < K; j++) a_q[i][j][c] <= '0;
                    s_q[i][c]   <= '0;
                    acc_q[i][c] <= '0;
`ifdef PMM_ADD_E_EN
                    e_q[i][c]   <= '0;
`endif
                end
            end
        end else begin
            mul_en <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int i = 0; i < K; i++) begin
                            for (int c = 0; c < N; c++) begin
                                for (int j = 0; j < K; j++) begin
                                    a_q[i][j][c] <= a_flat[((i*K+j)*N+c)*CW +: CW];
                                end
                                s_q[i][c]   <= s_flat[(i*N+c)*CW +: CW];
                                acc_q[i][c] <= '0;
`ifdef PMM_ADD_E_EN
                                e_q[i][c]   <= e_flat[(i*N+c)*CW +: CW];
`endif
                            end
                        end
                        // First product is issued straight from the ports; latched copies lag.
                        i_q      <= '0;
                        j_q      <= '0;
                        mul_en   <= 1'b1;
                        mul_a    <= a_flat[0 +: N*CW];
                        mul_b    <= s_flat[0 +: N*CW];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: state_q <= StAcc;
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    acc_q <= acc_upd;
                    if (to_done) begin
                        out_valid <= 1'b1;
                        t_flat    <= upd_flat;
                        state_q   <= StDone;
                    end
`ifdef PMM_ADD_E_EN
                    else if (to_adde) begin
                        state_q <= StAddE;
                    end
`endif
                    else begin
                        i_q     <= nxt_i;
                        j_q     <= nxt_j;
                        mul_en  <= 1'b1;
                        mul_a   <= issue_a;
                        mul_b   <= issue_b;
                        state_q <= StIssue;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_matvec_scheduler.sv
// Directed bench for poly_matvec_scheduler with a behavioural negacyclic multiplier.
module tb_poly_matvec_scheduler;

    localparam int K  = 2;
    localparam int N  = 4;
    localparam int Q  = 17;
    localparam int CW = 32;
    localparam int W  = K*N*CW;
`ifdef PMM_ADD_E_EN
    localparam int LAT = 11;
    localparam logic [15:0] MUL_MASK = 16'b0000_0001_0100_1010;  // issue at 1,3,6,8
`else
    localparam int LAT = 9;
    localparam logic [15:0] MUL_MASK = 16'b0000_0000_1010_1010;  // issue at 1,3,5,7
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [K*K*N*CW-1:0] a_flat = '0;
    logic [W-1:0]     s_flat = '0;
`ifdef PMM_ADD_E_EN
    logic [W-1:0]     e_flat = '0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     t_flat;
    logic             mul_en;
    logic [N*CW-1:0]  mul_a, mul_b;
    logic [N*CW-1:0]  mul_res = '0;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poly_matvec_scheduler #(.K(K), .N(N), .Q(Q), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .s_flat    (s_flat),
`ifdef PMM_ADD_E_EN
        .e_flat    (e_flat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .t_flat    (t_flat),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res),
        .busy      (busy)
    );

    // Registered multiplier in Z_Q[x]/(x^N+1) with a truncating remainder.
    function automatic logic [N*CW-1:0] nega(input logic [N*CW-1:0] a, input logic [N*CW-1:0] b);
        int sum [N];
        logic [N*CW-1:0] r;
        for (int k = 0; k < N; k++) sum[k] = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int p;
                p = $signed(a[i*CW +: CW]) * $signed(b[j*CW +: CW]);
                if (i + j < N) sum[i+j] += p;
                else           sum[i+j-N] -= p;
            end
        end
        for (int k = 0; k < N; k++) r[k*CW +: CW] = CW'(sum[k] % Q);
        return r;
    endfunction

    always @(posedge clk) if (mul_en) mul_res <= nega(mul_a, mul_b);

    function automatic logic [N*CW-1:0] poly(input int c0, input int c1, input int c2, input int c3);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Handshake, then check the cycle-by-cycle schedule up to the first out_valid.
    task automatic run_job(input string tag, input logic [W-1:0] exp_t);
        logic [15:0] mask;
        int guard;
        mask  = MUL_MASK;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, " in_ready before job"}, in_ready, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= LAT; cyc++) begin
            check($sformatf("%s mul_en c%0d", tag, cyc), mul_en, mask[cyc]);
            check($sformatf("%s out_valid c%0d", tag, cyc), out_valid, (cyc == LAT) ? 1 : 0);
            check($sformatf("%s busy c%0d", tag, cyc), busy, 1);
            if (cyc < LAT) tick();
        end
        check({tag, " t_flat"}, t_flat, exp_t);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after consume"}, in_ready, 1);
        check({tag, " out_valid after consume"}, out_valid, 0);
        check({tag, " busy after consume"}, busy, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " in_ready"}, in_ready, 1);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " mul_en"}, mul_en, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    logic [W-1:0] ident_t;

    initial begin
        ident_t = {poly(5, 6, 7, 8), poly(1, 2, 3, 4)};
        tick();
        tick();
        check_reset_state("reset");
        check("reset mul_a", mul_a, 0);
        check("reset mul_b", mul_b, 0);
        check("reset t_flat", t_flat, 0);
        rst = 1'b0;

        // Identity matrix, then hold the result under back-pressure.
        a_flat = {poly(1, 0, 0, 0), poly(0, 0, 0, 0), poly(0, 0, 0, 0), poly(1, 0, 0, 0)};
        s_flat = {poly(5, 6, 7, 8), poly(1, 2, 3, 4)};
        run_job("ident", ident_t);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            tick();
            check($sformatf("bp out_valid %0d", k), out_valid, 1);
            check($sformatf("bp t_flat %0d", k), t_flat, ident_t);
            check($sformatf("bp in_ready %0d", k), in_ready, 0);
            check($sformatf("bp mul_en %0d", k), mul_en, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp no bypass in_ready", in_ready, 0);
        tick();
        out_ready = 1'b0;
        check("bp release in_ready", in_ready, 1);
        check("bp release out_valid", out_valid, 0);

        // Multiplication by x wraps the top coefficient with a sign flip.
        a_flat = {poly(0, 0, 0, 0), poly(0, 0, 0, 0), poly(0, 0, 0, 0), poly(0, 1, 0, 0)};
        s_flat = {poly(0, 0, 0, 0), poly(1, 2, 3, 4)};
        run_job("nega", {poly(0, 0, 0, 0), poly(13, 1, 2, 3)});
        consume("nega");

        // Each product is [1,1,1,1]; two per row.
        a_flat = {poly(16, 0, 0, 0), poly(16, 0, 0, 0), poly(16, 0, 0, 0), poly(16, 0, 0, 0)};
        s_flat = {poly(16, 16, 16, 16), poly(16, 16, 16, 16)};
        run_job("accwrap", {poly(2, 2, 2, 2), poly(2, 2, 2, 2)});
        consume("accwrap");

        // Reset during cycle 4 of a job, then rerun the identity job.
        a_flat = {poly(1, 0, 0, 0), poly(0, 0, 0, 0), poly(0, 0, 0, 0), poly(1, 0, 0, 0)};
        s_flat = {poly(5, 6, 7, 8), poly(1, 2, 3, 4)};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_state("midrst");
        rst = 1'b0;
        run_job("rerun", ident_t);
        consume("rerun");

`ifdef PMM_ADD_E_EN
        e_flat = {poly(16, 0, 0, 0), poly(1, 1, 1, 1)};
        run_job("adde", {poly(4, 6, 7, 8), poly(2, 3, 4, 5)});
        consume("adde");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/poly_matvec_scheduler.md
Name: poly_matvec_scheduler

Overview:
- Sequences the shared registered polynomial multiplier (one product per enable pulse, ring Z_Q[x]/(x^N+1), registered result) to compute the Baby Kyber matrix-vector product t = A·s.
- A is a KxK matrix of polynomials; s is a K-vector of polynomials.
- Accepts one job via valid/ready, issues the K*K products in row-major order, and accumulates them mod Q.
- Presents the K result polynomials via valid/ready. Sits between the key-gen/encrypt top-level and the multiplier instance.

Parameters:
K, 2, matrix/vector dimension
N, 4, coefficients per polynomial
Q, 17, modulus
CW, 32, coefficient width (signed), matching the multiplier

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  job offered
in_ready  out  1  scheduler can accept a job
a_flat  in  K*K*N*CW  matrix A; coeff c of A[i][j] at bits [((i*K+j)*N+c)*CW +: CW]
s_flat  in  K*N*CW  vector s; coeff c of s[j] at [(j*N+c)*CW +: CW]
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
t_flat  out  K*N*CW  result t; same packing as s_flat; each coeff in [0,Q-1]
mul_en  out  1  enable to multiplier
mul_a  out  N*CW  multiplier polynomial1 (A[i][j])
mul_b  out  N*CW  multiplier polynomial2 (s[j])
mul_res  in  N*CW  multiplier polynomial_out (registered, valid the cycle after mul_en)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: in_ready=1, out_valid=0, mul_en=0, busy=0, mul_a=mul_b=0, t_flat=0, all counters and accumulators 0. State=IDLE.
- Input coefficients must be in [0,Q-1]. mul_res coefficients lie in (-Q,Q) (truncating remainder).
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a_flat and s_flat, clear acc[K][N], set i=j=0, go to ISSUE. Later changes on the input ports are ignored.
  - ISSUE: mul_en=1, mul_a=A[i][j], mul_b=s[j]. Go to ACC next cycle.
  - ACC: mul_en=0. For each coeff, r = mul_res<0 ? mul_res+Q : mul_res, then acc[i][c] = acc[i][c]+r, minus Q if the sum is >=Q. If j<K-1, increment j. Otherwise, if i<K-1, set j=0 and increment i. After the last pair go to DONE; otherwise go to ISSUE.
  - DONE: out_valid=1, t_flat=acc. Hold both stable until out_ready. On out_ready go to IDLE.
- in_ready is low in every state except IDLE. in_valid outside IDLE is ignored.
- No bypass: out_ready in DONE leaves in_ready=0 that cycle. A new job can be accepted the following cycle at the earliest.
- Latency: handshake at cycle 0 -> ISSUE at cycles 1,3,5,... and ACC at cycles 2,4,... -> out_valid first high at cycle 2*K*K+1 (cycle 9 for K=2).
- mul_en is a single-cycle pulse per product, never asserted in two consecutive cycles.
- rst mid-operation: the next cycle is in the reset state (IDLE, out_valid=0, mul_en=0). The partial accumulation is discarded.
- Arithmetic: the accumulator is CW bits but always held in [0,Q-1]. No intermediate value exceeds 2Q-2.

Optional Feature:
PMM_ADD_E_EN
- Defined:
  - Adds input port e_flat (K*N*CW, packing as s_flat, coeffs in [0,Q-1]), latched with A and s.
  - Adds state ADDE, entered after the ACC of the last product of each row (j=K-1). ADDE adds e[i] to acc[i] mod Q with the same conditional subtract, then continues to the next row's ISSUE or to DONE.
  - Computes t = A·s + e. Latency becomes 2*K*K+K+1 (cycle 11 for K=2).
- Undefined: no e_flat port, no ADDE state; behaviour exactly as above.

Test Plan:
- Identity: A=[[1,0],[0,1]] (constant polys), s0=[1,2,3,4], s1=[5,6,7,8] -> t0=[1,2,3,4], t1=[5,6,7,8]. out_valid rises at cycle 9. mul_en pulses at cycles 1,3,5,7 only.
- Negacyclic wrap: A[0][0]=x=[0,1,0,0], all other A zero, s0=[1,2,3,4], s1=0 -> t0=[13,1,2,3] (mul_res coeff0=-4 normalized), t1=[0,0,0,0].
- Accumulate wrap: every A[i][j]=[16,0,0,0], s0=s1=[16,16,16,16] -> each product [1,1,1,1], so t0=t1=[2,2,2,2].
- Back-pressure: complete the identity job, hold out_ready=0 for 10 cycles while pulsing in_valid -> out_valid and t_flat stay stable, in_ready=0, no second job starts. Raise out_ready -> in_ready=1 on the following cycle.
- Reset mid-job: assert rst at cycle 4 of a job -> next cycle in_ready=1, out_valid=0, mul_en=0, busy=0. Rerunning the identity job gives the correct result at cycle 9.
- With PMM_ADD_E_EN: identity job plus e0=[1,1,1,1], e1=[16,0,0,0] -> t0=[2,3,4,5], t1=[4,6,7,8]. out_valid rises at cycle 11.
